// File: rtl/rv32i_types.sv
// Shared fetch-side types: the fetch queue entry, the fetch controller state
// and the default boot address.
package rv32i_types;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h6000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_queue_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the I-side memory port and the fetch queue port seen by fetch_ctrl.
interface fetch_ctrl_if;
  import rv32i_types::*;

  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;

  logic         q_push;
  fetch_queue_t q_data;
  logic         q_pop;
  logic         q_empty;
  logic         q_clear;

  modport master (
    output imem_req, imem_addr, q_push, q_data, q_clear,
    input  imem_gnt, imem_rvalid, imem_rdata, q_pop, q_empty
  );

  modport slave (
    input  imem_req, imem_addr, q_push, q_data, q_clear,
    output imem_gnt, imem_rvalid, imem_rdata, q_pop, q_empty
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues in-order pipelined I-memory reads under queue credits
// and an outstanding-read cap, pushes responses into the fetch queue, and
// squashes stale responses after a redirect.
module fetch_ctrl
  import rv32i_types::*;
#(
  parameter int          QUEUE_ADDR_WIDTH = 4,
  parameter int          MAX_OUTSTANDING  = 2,
  parameter logic [31:0] RESET_PC         = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_ctrl_if.master      bus,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc
);

  localparam int QUEUE_DEPTH = 1 << QUEUE_ADDR_WIDTH;
  localparam int CW          = QUEUE_ADDR_WIDTH + 1;
  localparam int OW          = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CW-1:0] CREDIT_FULL = CW'(QUEUE_DEPTH);
  localparam logic [OW-1:0] OUT_MAX     = OW'(MAX_OUTSTANDING);

  fetch_state_t  state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0] credits_reg, credits_next;
  logic [OW-1:0] outstanding_reg, outstanding_next;
  logic [OW-1:0] squash_reg, squash_next;
  logic          q_clear_reg;

  logic issue;
  logic pop_ok;
  logic rsp_ok;

  assign issue  = bus.imem_req && bus.imem_gnt;
  // A pop in the redirect cycle is ignored: credits are reloaded to full anyway.
  assign pop_ok = bus.q_pop && !bus.q_empty && !redirect;
  assign rsp_ok = bus.imem_rvalid && (outstanding_reg != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = (outstanding_next != '0) ? DRAIN : RUN;
    end else if (state_reg == DRAIN && rsp_ok && squash_reg == OW'(1)) begin
      state_next = RUN;
    end
  end

  // Output logic; gated by rst_n so nothing is requested while held in reset
  always_comb begin
    bus.imem_req = 1'b0;
    bus.q_push   = 1'b0;
    if (rst_n && state_reg == RUN && !redirect) begin
      bus.imem_req = (credits_reg != '0) && (outstanding_reg != OUT_MAX);
      bus.q_push   = rsp_ok;
    end
  end

  assign bus.imem_addr = fetch_pc_reg;
  assign bus.q_data    = fetch_queue_t'({resp_pc_reg, bus.imem_rdata});
  assign bus.q_clear   = q_clear_reg;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (issue && !rsp_ok) begin
      outstanding_next = outstanding_reg + OW'(1);
    end else if (!issue && rsp_ok) begin
      outstanding_next = outstanding_reg - OW'(1);
    end
  end

  // Every read still in flight after a redirect cycle is stale.
  always_comb begin
    squash_next = squash_reg;
    if (redirect) begin
      squash_next = outstanding_next;
    end else if (state_reg == DRAIN && rsp_ok && squash_reg != '0) begin
      squash_next = squash_reg - OW'(1);
    end
  end

  always_comb begin
    credits_next = credits_reg;
    if (redirect) begin
      credits_next = CREDIT_FULL;
    end else if (issue && !pop_ok) begin
      credits_next = credits_reg - CW'(1);
    end else if (!issue && pop_ok && credits_reg != CREDIT_FULL) begin
      credits_next = credits_reg + CW'(1);
    end
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    if (redirect) begin
      fetch_pc_next = word_align(redirect_pc);
      resp_pc_next  = word_align(redirect_pc);
    end else begin
      if (issue) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (bus.q_push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      credits_reg     <= CREDIT_FULL;
      outstanding_reg <= '0;
      squash_reg      <= '0;
      q_clear_reg     <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      credits_reg     <= credits_next;
      outstanding_reg <= outstanding_next;
      squash_reg      <= squash_next;
      q_clear_reg     <= redirect;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level model (in-flight read list,
// credit count, fetch PC) is checked against the DUT every cycle.
module tb_fetch_ctrl;
  import rv32i_types::*;

  localparam int          QAW   = 4;
  localparam int          DEPTH = 1 << QAW;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_ctrl_if bif();

  fetch_ctrl #(
    .QUEUE_ADDR_WIDTH(QAW),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bif),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } rd_t;

  rd_t         inflight[$];
  logic [31:0] mem_fifo[$];
  logic [31:0] issue_addrs[$];
  int          issue_cyc[$];
  logic [31:0] push_pcs[$];
  logic [31:0] m_pc = RPC;
  int          m_credits = DEPTH;
  bit          m_clear = 1'b0;
  int          clear_cnt = 0;
  int          q_count = 0;
  int          q_count_nx = 0;
  int          cyc = 0;
  bit          resp_en = 1'b0;
  bit          force_rv = 1'b0;

  assign bif.q_empty = (q_count == 0);

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the fetch queue occupancy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_count <= 0;
    else        q_count <= q_count_nx;
  end

  // Memory responder: one-cycle latency, in order, can be paused
  initial begin
    bif.imem_rvalid = 1'b0;
    bif.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bif.imem_rvalid = 1'b0;
      end else if (force_rv) begin
        bif.imem_rvalid = 1'b1;
        bif.imem_rdata  = 32'hDEAD_BEEF;
      end else if (resp_en && mem_fifo.size() != 0) begin
        bif.imem_rvalid = 1'b1;
        bif.imem_rdata  = mem_word(mem_fifo.pop_front());
      end else begin
        bif.imem_rvalid = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    bit          drain;
    bit          exp_req;
    bit          exp_push;
    logic [31:0] exp_pc;
    rd_t         e;
    int          qn;
    if (!rst_n) begin
      chk("rst_req",   32'(bif.imem_req), 32'd0);
      chk("rst_push",  32'(bif.q_push),   32'd0);
      chk("rst_clear", 32'(bif.q_clear),  32'd0);
      chk("rst_addr",  bif.imem_addr,     RPC);
      inflight.delete();
      mem_fifo.delete();
      m_pc       = RPC;
      m_credits  = DEPTH;
      m_clear    = 1'b0;
      q_count_nx = 0;
    end else begin
      drain = 1'b0;
      foreach (inflight[i]) if (inflight[i].stale) drain = 1'b1;
      exp_req = !drain && m_credits > 0 && inflight.size() < MAXO && !redirect;
      chk("imem_req",  32'(bif.imem_req), 32'(exp_req));
      chk("imem_addr", bif.imem_addr,     m_pc);
      chk("q_clear",   32'(bif.q_clear),  32'(m_clear));
      if (bif.q_clear) clear_cnt++;

      exp_push = 1'b0;
      exp_pc   = '0;
      if (bif.imem_rvalid && inflight.size() != 0) begin
        e = inflight.pop_front();
        if (!e.stale && !redirect) begin
          exp_push = 1'b1;
          exp_pc   = e.pc;
        end
      end
      chk("q_push", 32'(bif.q_push), 32'(exp_push));
      if (exp_push && bif.q_push) begin
        chk("q_data.pc",    bif.q_data.pc,    exp_pc);
        chk("q_data.instr", bif.q_data.instr, mem_word(exp_pc));
      end
      if (bif.q_push) begin
        push_pcs.push_back(bif.q_data.pc);
        $display("[TB] cyc %0d push pc=0x%08h instr=0x%08h", cyc, bif.q_data.pc, bif.q_data.instr);
      end

      qn = q_count;
      if (bif.q_push) qn++;
      if (bif.q_pop && q_count != 0) qn--;
      if (m_clear) qn = 0;
      q_count_nx = qn;

      if (bif.imem_req && bif.imem_gnt) begin
        mem_fifo.push_back(bif.imem_addr);
        issue_addrs.push_back(bif.imem_addr);
        issue_cyc.push_back(cyc);
        $display("[TB] cyc %0d issue addr=0x%08h", cyc, bif.imem_addr);
      end

      if (redirect) begin
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc      = {redirect_pc[31:2], 2'b00};
        m_credits = DEPTH;
      end else begin
        if (exp_req && bif.imem_gnt) begin
          inflight.push_back('{pc: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
          m_credits--;
        end
        if (bif.q_pop && q_count != 0 && m_credits < DEPTH) m_credits++;
      end
      m_clear = redirect;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n0, np, ni, c0, cs, rc;
    logic [31:0] a0;
    bif.imem_gnt = 1'b0;
    bif.q_pop    = 1'b0;

    // Reset, then free-run with no pops until the credits run out
    repeat (3) tick();
    chk("reset_addr_lit", bif.imem_addr, 32'h6000_0000);
    chk("reset_req_lit",  32'(bif.imem_req), 32'd0);
    bif.imem_gnt = 1'b1;
    resp_en      = 1'b1;
    rst_n        = 1'b1;
    repeat (30) tick();
    chk("free_issues",  32'(issue_addrs.size()), 32'd16);
    chk("free_pushes",  32'(push_pcs.size()),    32'd16);
    chk("free_addr0",   issue_addrs[0],  32'h6000_0000);
    chk("free_addr1",   issue_addrs[1],  32'h6000_0004);
    chk("free_push15",  push_pcs[15],    32'h6000_003C);
    chk("free_req_off", 32'(bif.imem_req), 32'd0);

    // Response with nothing outstanding is ignored
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    tick();
    chk("spurious_nopush", 32'(push_pcs.size()), 32'd16);

    // One pop from full releases exactly one issue, in the next cycle
    bif.q_pop = 1'b1;
    cs = cyc;
    tick();
    bif.q_pop = 1'b0;
    repeat (4) tick();
    chk("credit_issues", 32'(issue_addrs.size()), 32'd17);
    chk("credit_addr",   issue_addrs[16], 32'h6000_0040);
    chk("credit_cycle",  32'(issue_cyc[16]), 32'(cs + 1));
    chk("credit_push",   push_pcs[16], 32'h6000_0040);

    // Two reads outstanding, then redirect to a misaligned target
    resp_en   = 1'b0;
    bif.q_pop = 1'b1;
    repeat (4) tick();
    bif.q_pop = 1'b0;
    tick();
    chk("stale_issues", 32'(issue_addrs.size()), 32'd19);
    c0 = clear_cnt;
    redirect    = 1'b1;
    redirect_pc = 32'h6000_1002;
    rc = cyc;
    tick();
    redirect = 1'b0;
    chk("redir_clear_now", 32'(bif.q_clear), 32'd1);
    resp_en = 1'b1;
    repeat (6) tick();
    chk("redir_clear_cnt", 32'(clear_cnt - c0), 32'd1);
    chk("redir_new_addr",  issue_addrs[19], 32'h6000_1000);
    chk("redir_new_cycle", 32'(issue_cyc[19]), 32'(rc + 4));
    chk("redir_push_pc",   push_pcs[17], 32'h6000_1000);

    // Grant withheld for three cycles
    bif.imem_gnt = 1'b0;
    cs = cyc;
    a0 = bif.imem_addr;
    n0 = issue_addrs.size();
    tick();
    chk("stall_addr1", bif.imem_addr, a0);
    tick();
    chk("stall_addr2", bif.imem_addr, a0);
    tick();
    chk("stall_addr3", bif.imem_addr, a0);
    chk("stall_noissue", 32'(issue_addrs.size()), 32'(n0));
    bif.imem_gnt = 1'b1;
    tick();
    chk("stall_grant_addr",  issue_addrs[n0], a0);
    chk("stall_grant_cycle", 32'(issue_cyc[n0]), 32'(cs + 3));

    // Issue and pop together
    bif.q_pop = 1'b1;
    repeat (2) tick();
    bif.q_pop = 1'b0;
    tick();

    // Redirect in the same cycle as a response
    np = push_sz();
    ni = issue_addrs.size();
    redirect    = 1'b1;
    redirect_pc = 32'h6000_2000;
    rc = cyc;
    tick();
    redirect = 1'b0;
    tick();
    chk("rv_redir_nopush", 32'(push_pcs.size()), 32'(np));
    chk("rv_redir_addr",   issue_addrs[ni], 32'h6000_2000);
    chk("rv_redir_cycle",  32'(issue_cyc[ni]), 32'(rc + 1));

    // Second redirect while draining: newest target wins
    resp_en = 1'b0;
    repeat (3) tick();
    np = push_sz();
    ni = issue_addrs.size();
    c0 = clear_cnt;
    redirect    = 1'b1;
    redirect_pc = 32'h6000_2000;
    tick();
    redirect_pc = 32'h6000_3006;
    tick();
    redirect = 1'b0;
    resp_en  = 1'b1;
    repeat (6) tick();
    chk("drain2_addr",  issue_addrs[ni], 32'h6000_3004);
    chk("drain2_push",  push_pcs[np],    32'h6000_3004);
    chk("drain2_clear", 32'(clear_cnt - c0), 32'd2);

    // Asynchronous reset in the middle of a drain
    resp_en = 1'b0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h6000_4000;
    tick();
    redirect = 1'b0;
    chk("areset_pre_clear", 32'(bif.q_clear), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_req",   32'(bif.imem_req), 32'd0);
    chk("areset_addr",  bif.imem_addr,     32'h6000_0000);
    chk("areset_clear", 32'(bif.q_clear),  32'd0);
    chk("areset_push",  32'(bif.q_push),   32'd0);
    resp_en = 1'b1;
    repeat (3) tick();
    n0 = issue_addrs.size();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("restart_addr0", issue_addrs[n0],     32'h6000_0000);
    chk("restart_addr1", issue_addrs[n0 + 1], 32'h6000_0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  function automatic int push_sz();
    return push_pcs.size();
  endfunction

endmodule
